nyq_frame_packer: RTL
=====================

# nyq_frame_packer

Downstream consumer of the NYQ phase counter (3-bit, counts 7 down to 0, wraps). Collects one DATA_W-bit sample per counter phase into an 8-slot frame, aligned so that phase 7 opens a frame and phase 0 closes it. Each completed frame is presented on a valid/ready output port. Optionally checks phase continuity and resynchronises on error.

## Interface
Parameters:
- DATA_W, 8: width of one sample. Frame width is 8*DATA_W.

Ports:
- Clk_CI  in  1  clock, rising edge
- Rst_RBI  in  1  asynchronous, active-high reset
- En_SI  in  1  block enable; low = hold all state, ignore inputs
- Cnt_In_DI  in  3  phase index from the NYQ counter
- Smp_In_DI  in  DATA_W  sample belonging to phase Cnt_In_DI
- Smp_Valid_SI  in  1  sample and phase are valid this cycle
- Frm_Out_DO  out  8*DATA_W  assembled frame; slot k at bits [k*DATA_W +: DATA_W]
- Frm_Valid_SO  out  1  frame available
- Frm_Ready_SI  in  1  consumer accepts frame
- Sync_SO  out  1  high while in FILL (frame alignment held)
- Ovf_SO  out  1  sticky: a completed frame was dropped
- Err_SO  out  1  one-cycle pulse on phase discontinuity

## Operation
- A sample is accepted in a cycle where En_SI=1 and Smp_Valid_SI=1; all other cycles change no state, except for the output handshake.
- States:
  - SYNC (reset state): an accepted sample with Cnt_In_DI=7 is written to slot 7, sets expected phase to 6, and moves to FILL. Any other phase is discarded with no error.
  - FILL: an accepted sample is written to slot Cnt_In_DI, and expected phase decrements modulo 8.
- Phase 0 accepted in FILL completes the frame:
  - Frame moves to the output register if Frm_Valid_SO=0, or if Frm_Valid_SO=1 and Frm_Ready_SI=1 in the same cycle.
  - Otherwise the new frame is dropped, the output frame is kept, and Ovf_SO is set.
  - The state machine goes to SYNC; the next frame must start at phase 7.
- Phase check: an accepted sample in FILL with Cnt_In_DI != expected phase:
  - pulses Err_SO;
  - discards the partial frame;
  - returns to SYNC.
  - If that mismatching sample has phase 7, it is re-evaluated as a SYNC start in the same cycle: written to slot 7, state returns to FILL.
- Output handshake:
  - Transfer occurs when Frm_Valid_SO=1 and Frm_Ready_SI=1.
  - Frm_Valid_SO stays high and Frm_Out_DO stays stable until transfer.
  - Frm_Valid_SO clears after transfer unless a new frame loads in the same cycle.
- The handshake runs regardless of En_SI.
- Ovf_SO clears only on reset.
- Reset, asynchronous, also mid-frame: state goes to SYNC, the frame buffer and Frm_Out_DO clear to 0, and Frm_Valid_SO, Sync_SO, Ovf_SO and Err_SO clear to 0 immediately.

## Timing
- Frame complete (phase 0 accepted) in cycle N: Frm_Valid_SO=1 and Frm_Out_DO valid from cycle N+1.
- Sync_SO rises the cycle after phase 7 is accepted in SYNC.
- Sync_SO falls the cycle after completion or error.
- Err_SO is high for exactly the cycle after the offending sample.
- Back-to-back frames (8 consecutive accepted samples 7..0, repeated) with Frm_Ready_SI held at 1 sustain one frame per 8 accepted samples, with no drop.
- Minimum spacing between completed frames is 8 accepted samples; a single output register is enough when Ready is held high.

## Configuration
- NYQ_PHASE_CHECK_EN defined: the phase continuity check and Err_SO behave as described above.
- NYQ_PHASE_CHECK_EN undefined:
  - no expected-phase register;
  - in FILL, any accepted sample writes slot Cnt_In_DI;
  - the frame completes on phase 0 regardless of order;
  - Err_SO is tied to 0.

## Test plan
- Reset, then accepted samples 0xA7,0xA6,…,0xA0 with phases 7..0, Ready=1 -> Frm_Out_DO=0xA7A6A5A4A3A2A1A0 and Frm_Valid_SO=1 the cycle after phase 0; Ovf_SO=0.
- Samples with phases 3,2,1,0 before the first 7 -> ignored, Sync_SO=0, no frame. A following full 7..0 sequence -> one frame.
- Two full frames with Ready=0 -> first frame held unchanged; Ovf_SO=1 the cycle after the second frame's phase 0. Then Ready=1 -> first frame transfers, Frm_Valid_SO=0.
- With NYQ_PHASE_CHECK_EN: phases 7,6,4 -> Err_SO pulse after phase 4, Sync_SO=0. Then 7..0 -> a valid frame containing only the new samples.
- Rst_RBI asserted between phases 3 and 2, with a frame pending on the output -> all outputs 0 asynchronously. After release, the sequence 2,1,0 produces no frame.
- Smp_Valid_SI gaps and En_SI=0 cycles interleaved within 7..0 -> same frame as the gap-free case, one cycle after the final phase-0 acceptance.

Source files
------------

// File: rtl/nyq_frame_packer.sv
// Packs one sample per NYQ counter phase (7 down to 0) into an 8-slot frame and
// presents each completed frame on a valid/ready port. Optional phase check: NYQ_PHASE_CHECK_EN.
module nyq_frame_packer #(
    parameter int DATA_W = 8
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  En_SI,
    input  logic [2:0]            Cnt_In_DI,
    input  logic [DATA_W-1:0]     Smp_In_DI,
    input  logic                  Smp_Valid_SI,
    output logic [8*DATA_W-1:0]   Frm_Out_DO,
    output logic                  Frm_Valid_SO,
    input  logic                  Frm_Ready_SI,
    output logic                  Sync_SO,
    output logic                  Ovf_SO,
    output logic                  Err_SO
);

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [8*DATA_W-1:0] buf_q, buf_d;
    logic [8*DATA_W-1:0] frm_q, frm_d;
    logic                frm_valid_q, frm_valid_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;
`ifdef NYQ_PHASE_CHECK_EN
    logic [2:0]          exp_q, exp_d;
`endif

    logic       accept;
    logic       wr_en;
    logic       complete;
    logic       load;
    logic [7:0] slot_we;

    assign accept = En_SI & Smp_Valid_SI;

    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        complete = 1'b0;
        err_d    = 1'b0;
`ifdef NYQ_PHASE_CHECK_EN
        exp_d    = exp_q;
`endif
        if (accept) begin
            if (state_q == ST_SYNC) begin
                if (Cnt_In_DI == 3'd7) begin
                    wr_en   = 1'b1;
                    state_d = ST_FILL;
`ifdef NYQ_PHASE_CHECK_EN
                    exp_d   = 3'd6;
`endif
                end
            end else begin
`ifdef NYQ_PHASE_CHECK_EN
                if (Cnt_In_DI != exp_q) begin
                    // A mismatching phase 7 restarts a frame immediately.
                    err_d   = 1'b1;
                    state_d = ST_SYNC;
                    if (Cnt_In_DI == 3'd7) begin
                        wr_en   = 1'b1;
                        state_d = ST_FILL;
                        exp_d   = 3'd6;
                    end
                end else begin
                    wr_en = 1'b1;
                    exp_d = exp_q - 3'd1;
                    if (Cnt_In_DI == 3'd0) begin
                        complete = 1'b1;
                        state_d  = ST_SYNC;
                    end
                end
`else
                wr_en = 1'b1;
                if (Cnt_In_DI == 3'd0) begin
                    complete = 1'b1;
                    state_d  = ST_SYNC;
                end
`endif
            end
        end
    end

    // buf_d already holds the closing sample, so it is the completed frame.
    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
        assign slot_we[gi] = wr_en && (Cnt_In_DI == 3'(gi));
        assign buf_d[gi*DATA_W +: DATA_W] = slot_we[gi] ? Smp_In_DI
                                                        : buf_q[gi*DATA_W +: DATA_W];
    end

    assign load = complete & (~frm_valid_q | Frm_Ready_SI);

    always_comb begin
        frm_d       = load ? buf_d : frm_q;
        frm_valid_d = load | (frm_valid_q & ~Frm_Ready_SI);
        ovf_d       = ovf_q | (complete & ~load);
    end

    always_ff @(posedge Clk_CI or posedge Rst_RBI) begin
        if (Rst_RBI) begin
            state_q     <= ST_SYNC;
            buf_q       <= '0;
            frm_q       <= '0;
            frm_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
`ifdef NYQ_PHASE_CHECK_EN
            exp_q       <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            frm_q       <= frm_d;
            frm_valid_q <= frm_valid_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
`ifdef NYQ_PHASE_CHECK_EN
            exp_q       <= exp_d;
`endif
        end
    end

    assign Frm_Out_DO   = frm_q;
    assign Frm_Valid_SO = frm_valid_q;
    assign Sync_SO      = (state_q == ST_FILL);
    assign Ovf_SO       = ovf_q;
    assign Err_SO       = err_q;

endmodule
